// File: rtl/sprite_addr_cal.sv
// -----------------------------------------------------------------------------
// sprite_addr_cal
//
// Per-pixel sprite address calculator. Decides whether the current raster
// pixel lies inside a visible sprite and, if so, produces the pixel-memory
// address of that pixel's colour-index entry. One registered stage, one new
// result every clock.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   pattern_info in  80   {append, res_h, res_v, act_h, act_v}, 16 bits each
//   sprite_info  in  32   {visible, flip, x[9:0], y[9:0], reserved[9:0]}
//   hcount       in  10   current raster column
//   vcount       in  10   current raster row
//   addr_output  out 16   pixel-memory address (0 when not hit)
//   valid        out  1   pixel lies inside a visible sprite
// -----------------------------------------------------------------------------
module sprite_addr_cal (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] pattern_info,
  input  logic [31:0] sprite_info,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [15:0] addr_output,
  output logic        valid
);

  // Descriptor fields
  logic [15:0] append_s;
  logic [15:0] res_h_s;
  logic [15:0] res_v_s;
  logic [15:0] act_h_s;
  logic [15:0] act_v_s;
  logic        visible_s;
  logic        flip_s;
  logic [9:0]  x_s;
  logic [9:0]  y_s;

  // Datapath
  logic [16:0] dx_s;
  logic [16:0] dy_s;
  logic        in_h_s;
  logic        in_v_s;
  logic        scale_h_s;
  logic        scale_v_s;
  logic [15:0] sx_s;
  logic [15:0] sy_s;
  logic [15:0] col_s;
  logic [15:0] row_off_s;
  logic [15:0] addr_s;
  logic        hit_s;

  // Registered outputs
  logic [15:0] addr_d;
  logic [15:0] addr_q;
  logic        valid_d;
  logic        valid_q;

  // Reserved placement bits are deliberately ignored.
  logic        rsvd_unused_s;

  assign append_s      = pattern_info[79:64];
  assign res_h_s       = pattern_info[63:48];
  assign res_v_s       = pattern_info[47:32];
  assign act_h_s       = pattern_info[31:16];
  assign act_v_s       = pattern_info[15:0];
  assign visible_s     = sprite_info[31];
  assign flip_s        = sprite_info[30];
  assign x_s           = sprite_info[29:20];
  assign y_s           = sprite_info[19:10];
  assign rsvd_unused_s = ^sprite_info[9:0];

  // Hit test, per-axis scaling, flip and address arithmetic.
  always_comb begin
    dx_s      = {7'd0, hcount} - {7'd0, x_s};
    dy_s      = {7'd0, vcount} - {7'd0, y_s};

    // Bounds compared at 17 bits so x + act_h past 1023 never wraps.
    in_h_s    = (hcount >= x_s) && (dx_s < {1'b0, act_h_s});
    in_v_s    = (vcount >= y_s) && (dy_s < {1'b0, act_v_s});
    hit_s     = visible_s && in_h_s && in_v_s;

    // 2:1 upscaling only when displayed size is exactly twice the stored size;
    // every other ratio indexes 1:1 without clamping.
    scale_h_s = ({1'b0, act_h_s} == {res_h_s, 1'b0});
    scale_v_s = ({1'b0, act_v_s} == {res_v_s, 1'b0});

    if (scale_h_s) begin
      sx_s = dx_s[16:1];
    end else begin
      sx_s = dx_s[15:0];
    end

    if (scale_v_s) begin
      sy_s = dy_s[16:1];
    end else begin
      sy_s = dy_s[15:0];
    end

    if (flip_s) begin
      col_s = res_h_s - 16'd1 - sx_s;
    end else begin
      col_s = sx_s;
    end

    // Only the low 16 bits of the product matter: the address wraps mod 2^16.
    row_off_s = sy_s * res_h_s;
    addr_s    = append_s + row_off_s + col_s;

    if (hit_s) begin
      addr_d  = addr_s;
      valid_d = 1'b1;
    end else begin
      addr_d  = 16'd0;
      valid_d = 1'b0;
    end
  end

  // Output register; reset clears the result immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= 16'd0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign addr_output = addr_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_sprite_addr_cal.sv
// -----------------------------------------------------------------------------
// tb_sprite_addr_cal
//
// Scoreboard bench for sprite_addr_cal. The stimulus process drives inputs on
// the falling edge and pushes the expected {valid, addr} into a queue; a
// monitor pops one entry after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_sprite_addr_cal;

  logic        clk;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] addr_output;
  logic        valid;

  typedef struct {
    logic        v;
    logic [15:0] a;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  sprite_addr_cal dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act_v, input logic [15:0] act_a,
                       input logic exp_v, input logic [15:0] exp_a);
    checks++;
    if (act_v !== exp_v || act_a !== exp_a) begin
      errors++;
      $display("FAIL %s: got valid=%0b addr=%0d, expected valid=%0b addr=%0d",
               name, act_v, act_a, exp_v, exp_a);
    end
  endtask

  // Reference model: plain integer arithmetic straight from the rules.
  function automatic logic [16:0] model(input logic [79:0] pat, input logic [31:0] spr,
                                       input int h, input int v);
    longint append, res_h, res_v, act_h, act_v, x, y, dx, dy, sx, sy, col, addr;
    append = pat[79:64]; res_h = pat[63:48]; res_v = pat[47:32];
    act_h  = pat[31:16]; act_v = pat[15:0];
    x = spr[29:20]; y = spr[19:10];
    dx = h - x; dy = v - y;
    if (!(spr[31] && dx >= 0 && dx < act_h && dy >= 0 && dy < act_v))
      return 17'd0;
    sx = (act_h == 2 * res_h) ? dx / 2 : dx;
    sy = (act_v == 2 * res_v) ? dy / 2 : dy;
    col = spr[30] ? (res_h - 1 - sx) : sx;
    addr = append + sy * res_h + col;
    addr = ((addr % 65536) + 65536) % 65536;
    return {1'b1, addr[15:0]};
  endfunction

  function automatic logic [79:0] pat(input int app, input int rh, input int rv,
                                      input int ah, input int av);
    logic [15:0] f0, f1, f2, f3, f4;
    f0 = app[15:0]; f1 = rh[15:0]; f2 = rv[15:0]; f3 = ah[15:0]; f4 = av[15:0];
    return {f0, f1, f2, f3, f4};
  endfunction

  function automatic logic [31:0] spr(input logic vis, input logic flp,
                                      input int x, input int y, input int rsvd);
    logic [9:0] fx, fy, fr;
    fx = x[9:0]; fy = y[9:0]; fr = rsvd[9:0];
    return {vis, flp, fx, fy, fr};
  endfunction

  // Apply inputs now and record the expected result for the next rising edge.
  task automatic apply(input string name, input logic [79:0] p, input logic [31:0] s,
                       input int h, input int v, input logic ev, input logic [15:0] ea);
    exp_t e;
    pattern_info = p;
    sprite_info  = s;
    hcount       = h[9:0];
    vcount       = v[9:0];
    e.v = ev; e.a = ea; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic dir(input string name, input logic [79:0] p, input logic [31:0] s,
                     input int h, input int v, input logic ev, input logic [15:0] ea);
    @(negedge clk);
    apply(name, p, s, h, v, ev, ea);
  endtask

  // Monitor: one result per rising edge while out of reset.
  always @(posedge clk) begin
    #1;
    if (reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, valid, addr_output, e.v, e.a);
    end
  end

  initial begin
    logic [79:0] p;
    logic [31:0] s;
    logic [16:0] m;
    int rh, rv, ah, av, x, y, h, v;

    reset        = 1'b0;
    pattern_info = 80'd0;
    sprite_info  = 32'd0;
    hcount       = 10'd0;
    vcount       = 10'd0;
    #2;
    check("reset_state", valid, addr_output, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    check("reset_held", valid, addr_output, 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    p = pat(0, 32, 40, 32, 40);
    dir("tl_corner",   p, spr(1'b1, 1'b0, 100, 50, 0),     100, 50, 1'b1, 16'd0);
    dir("br_corner",   p, spr(1'b1, 1'b0, 100, 50, 10'h3FF), 131, 89, 1'b1, 16'd1279);
    dir("right_out",   p, spr(1'b1, 1'b0, 100, 50, 0),     132, 89, 1'b0, 16'd0);
    dir("left_out",    p, spr(1'b1, 1'b0, 100, 50, 0),      99, 50, 1'b0, 16'd0);
    dir("below_out",   p, spr(1'b1, 1'b0, 100, 50, 0),     100, 90, 1'b0, 16'd0);
    dir("flip_tl",     p, spr(1'b1, 1'b1, 100, 50, 0),     100, 50, 1'b1, 16'd31);
    dir("flip_row1",   p, spr(1'b1, 1'b1, 100, 50, 0),     131, 51, 1'b1, 16'd32);
    dir("append_1280", pat(1280, 32, 40, 32, 40), spr(1'b1, 1'b0, 100, 50, 0), 103, 52, 1'b1, 16'd1347);
    dir("append_max",  pat(65535, 32, 40, 32, 40), spr(1'b1, 1'b0, 100, 50, 0), 100, 50, 1'b1, 16'd65535);
    dir("append_wrap", pat(65535, 32, 40, 32, 40), spr(1'b1, 1'b0, 100, 50, 0), 101, 50, 1'b1, 16'd0);
    p = pat(0, 16, 20, 32, 40);
    dir("scale_mid",   p, spr(1'b1, 1'b0, 100, 50, 0),     105, 57, 1'b1, 16'd50);
    dir("scale_br",    p, spr(1'b1, 1'b0, 100, 50, 0),     131, 89, 1'b1, 16'd319);
    dir("scale_out",   p, spr(1'b1, 1'b0, 100, 50, 0),     132, 89, 1'b0, 16'd0);
    p = pat(0, 32, 40, 32, 40);
    dir("invisible",   p, spr(1'b0, 1'b0, 100, 50, 0),     110, 60, 1'b0, 16'd0);
    dir("edge_1023",   p, spr(1'b1, 1'b0, 1020, 50, 0),   1023, 50, 1'b1, 16'd3);
    dir("edge_nowrap", p, spr(1'b1, 1'b0, 1020, 50, 0),      2, 50, 1'b0, 16'd0);
    dir("act_zero",    pat(0, 32, 40, 0, 40), spr(1'b1, 1'b0, 100, 50, 0), 100, 50, 1'b0, 16'd0);

    // Asynchronous reset between edges
    dir("pre_reset_hit", p, spr(1'b1, 1'b0, 100, 50, 0), 131, 89, 1'b1, 16'd1279);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_clear", valid, addr_output, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    check("reset_hold_edge", valid, addr_output, 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    apply("post_reset", p, spr(1'b1, 1'b0, 100, 50, 0), 103, 52, 1'b1, 16'd67);

    // Randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      rh = $urandom_range(1, 64);
      rv = $urandom_range(1, 64);
      case ($urandom_range(0, 2))
        0:       ah = 2 * rh;
        1:       ah = rh;
        default: ah = $urandom_range(0, 100);
      endcase
      case ($urandom_range(0, 2))
        0:       av = 2 * rv;
        1:       av = rv;
        default: av = $urandom_range(0, 100);
      endcase
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 1023);
      h = x + $urandom_range(0, ah + 4) - 2;
      v = y + $urandom_range(0, av + 4) - 2;
      if (h < 0) h = 0;
      if (h > 1023) h = 1023;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      p = pat($urandom_range(0, 65535), rh, rv, ah, av);
      s = spr($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, x, y,
              $urandom_range(0, 1023));
      m = model(p, s, h, v);
      dir("random", p, s, h, v, m[16], m[15:0]);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_addr_cal.md
# sprite_addr_cal

Per-pixel sprite address calculator for the VGA sprite pipeline. From a sprite's pattern descriptor (base address, stored resolution, on-screen size) and its placement word (visibility, flip, position), it decides whether the current raster pixel (hcount, vcount) falls inside the sprite. If it does, it produces the on-chip pixel-memory address of the colour-index entry for that pixel. One instance sits per sprite buffer in each display component; its outputs feed the palette lookup.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- pattern_info  in  80  pattern descriptor: [79:64] append (base address), [63:48] res_h (stored width), [47:32] res_v (stored height), [31:16] act_h (displayed width), [15:0] act_v (displayed height); all unsigned.
- sprite_info  in  32  placement: [31] visible, [30] flip (horizontal mirror), [29:20] x (left column), [19:10] y (top row), [9:0] reserved, ignored.
- hcount  in  10  current raster column, one count per pixel.
- vcount  in  10  current raster row.
- addr_output  out  16  pixel-memory address for the sampled pixel.
- valid  out  1  sampled pixel lies inside a visible sprite.

## Operation
- dx = hcount − x, dy = vcount − y. Compute both at ≥17 bits so there is no wrap.
- Hit condition: visible=1 AND hcount ≥ x AND dx < act_h AND vcount ≥ y AND dy < act_v. Bounds are compared at full width, so x + act_h beyond 1023 does not wrap. act_h=0 or act_v=0 never hits.
- Scaling, decided per axis:
  - act == 2·res → source coordinate = d >> 1.
  - Any other relation → source coordinate = d (1:1). Values beyond the stored image still index linearly; no clamping.
- Column: col = sx when flip=0; col = res_h − 1 − sx when flip=1. Row: row = sy. Vertical flip is not supported.
- Address: addr = append + row·res_h + col, truncated to 16 bits (mod 65536).
- On a hit: valid=1, addr_output=addr. Otherwise: valid=0, addr_output=0.
- sprite_info[9:0] has no effect.

## Timing
- Fully registered outputs. Inputs sampled at rising edge N drive addr_output/valid after edge N. Latency is exactly 1 clock. There is one new result every cycle and no handshake.
- Combinational multiply (16×16, low 16 bits used) sits within the single stage.
- Reset (reset=0): addr_output=0 and valid=0 immediately and asynchronously. They stay 0 while reset is low. The first registered result appears on the first rising edge after reset deasserts.
- Reset asserted mid-frame clears the outputs at once, with no partial result afterwards.
- Input changes between edges do not affect outputs until the next edge.
- Simultaneous change of sprite_info and hcount/vcount: the result uses the values present at that edge only.

## Test plan
- pattern {0,32,40,32,40}, sprite visible, flip=0, x=100, y=50. (100,50) → valid=1, addr=0. (131,89) → addr=1279. (132,89) → valid=0, addr=0. (99,50) → valid=0. Each result appears one cycle after its input.
- Same setup with flip=1: (100,50) → addr=31. (131,51) → addr=32.
- Append=1280, x=100, y=50, pixel (103,52) → addr=1347. Append=65535, pixel (100,50) → addr=65535. Same with (101,50) → addr=0 (wrap).
- 2:1 scaling, pattern {0,16,20,32,40}: (105,57) → addr=50. (131,89) → addr=319. (132,89) → valid=0.
- visible=0 at an inside pixel → valid=0. x=1020, act_h=32: hcount=1023 → valid=1, col=3, no wrap to low columns.
- Drive a hit, assert reset asynchronously between edges → outputs 0 before the next edge. Release reset → correct result one cycle later.
